// File: rtl/circular_buffer.sv
// Flit FIFO for NoC router input ports: circular memory with read/write pointers,
// occupancy counter and first-word fall-through head output.
package noc_params;
  typedef struct packed {
    logic [3:0]  vc_id;
    logic [3:0]  x_dest;
    logic [3:0]  y_dest;
    logic [19:0] head_pl;
  } flit_t;
endpackage

module circular_buffer
  import noc_params::*;
#(
  parameter int BUFFER_SIZE = 8
) (
  input  logic  clk,
  input  logic  rst,
  input  flit_t data_i,
  input  logic  write_i,
  input  logic  read_i,
  output flit_t data_o,
  output logic  is_full_o,
  output logic  is_empty_o
);
  localparam int PTR_W = (BUFFER_SIZE > 1) ? $clog2(BUFFER_SIZE) : 1;
  localparam int CNT_W = $clog2(BUFFER_SIZE + 1);
  localparam logic [PTR_W-1:0] LAST = PTR_W'(BUFFER_SIZE - 1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(BUFFER_SIZE);

  flit_t            mem [BUFFER_SIZE];
  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic [CNT_W-1:0] count;
  logic             do_rd, do_wr;

  // A read frees a slot in the same edge, so a full buffer still takes a write alongside it.
  assign do_rd = rst && read_i && (count != '0);
  assign do_wr = rst && write_i && ((count != FULL) || do_rd);

  assign data_o     = mem[rd_ptr];
  assign is_full_o  = (count == FULL);
  assign is_empty_o = (count == '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_rd) rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
      if (do_wr) wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
      if (do_wr && !do_rd)      count <= count + 1'b1;
      else if (do_rd && !do_wr) count <= count - 1'b1;
    end
  end

  // Storage is never cleared; stale entries are unreachable once the pointers reset.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= data_i;
  end

endmodule

// File: tb/tb_circular_buffer.sv
// Directed bench for circular_buffer: order, overflow, simultaneous access,
// random wrap-around against a queue model, and asynchronous reset.
module tb_circular_buffer;
  import noc_params::*;

  logic  clk = 1'b0;
  logic  rst = 1'b0;
  flit_t data_i = '0;
  logic  write_i = 1'b0;
  logic  read_i = 1'b0;
  flit_t data_o;
  logic  is_full_o, is_empty_o;

  int errors = 0;
  int checks = 0;

  circular_buffer #(.BUFFER_SIZE(8)) dut (
    .clk(clk), .rst(rst), .data_i(data_i), .write_i(write_i), .read_i(read_i),
    .data_o(data_o), .is_full_o(is_full_o), .is_empty_o(is_empty_o)
  );

  always #5 clk = ~clk;

  function automatic flit_t mk(input logic [3:0] v);
    flit_t f;
    f.vc_id = v; f.x_dest = v; f.y_dest = v; f.head_pl = 20'(v);
    return f;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one request cycle; returns #1 after the edge with inputs idle.
  task automatic step(input logic w, input logic r, input flit_t d);
    write_i = w; read_i = r; data_i = d;
    @(posedge clk); #1;
    write_i = 1'b0; read_i = 1'b0; data_i = '0;
  endtask

  initial begin
    flit_t sb[$];
    flit_t rv;
    logic  w, r, rd_ok, wr_ok;
    int    acc_wr;

    // Reset then idle
    #12 rst = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      chk("idle_empty", 64'(is_empty_o), 64'd1);
      chk("idle_full", 64'(is_full_o), 64'd0);
      @(posedge clk); #1;
    end

    // Order preservation
    for (int i = 1; i <= 3; i++) step(1'b1, 1'b0, mk(4'(i)));
    chk("order_nonempty", 64'(is_empty_o), 64'd0);
    for (int i = 1; i <= 3; i++) begin
      chk($sformatf("order_head%0d", i), 64'(data_o), 64'(mk(4'(i))));
      step(1'b0, 1'b1, '0);
    end
    chk("order_empty", 64'(is_empty_o), 64'd1);

    // Fill and overflow
    for (int i = 0; i < 8; i++) begin
      chk("fill_notfull", 64'(is_full_o), 64'd0);
      step(1'b1, 1'b0, mk(4'(i)));
    end
    chk("fill_full", 64'(is_full_o), 64'd1);
    chk("fill_notempty", 64'(is_empty_o), 64'd0);
    step(1'b1, 1'b0, mk(4'd9));
    chk("ovf_full", 64'(is_full_o), 64'd1);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("ovf_head%0d", i), 64'(data_o), 64'(mk(4'(i))));
      step(1'b0, 1'b1, '0);
    end
    chk("ovf_empty", 64'(is_empty_o), 64'd1);
    chk("ovf_notfull", 64'(is_full_o), 64'd0);

    // Read while empty is ignored
    step(1'b0, 1'b1, '0);
    chk("rd_empty_ignored", 64'(is_empty_o), 64'd1);

    // Simultaneous read+write with A,B queued
    step(1'b1, 1'b0, mk(4'hA));
    step(1'b1, 1'b0, mk(4'hB));
    chk("sim_headA", 64'(data_o), 64'(mk(4'hA)));
    step(1'b1, 1'b1, mk(4'hC));
    chk("sim_notempty", 64'(is_empty_o), 64'd0);
    chk("sim_notfull", 64'(is_full_o), 64'd0);
    chk("sim_headB", 64'(data_o), 64'(mk(4'hB)));
    step(1'b0, 1'b1, '0);
    chk("sim_headC", 64'(data_o), 64'(mk(4'hC)));
    step(1'b0, 1'b1, '0);
    chk("sim_empty", 64'(is_empty_o), 64'd1);

    // Read+write while empty: write only
    step(1'b1, 1'b1, mk(4'h5));
    chk("rw_empty_nonempty", 64'(is_empty_o), 64'd0);
    chk("rw_empty_head", 64'(data_o), 64'(mk(4'h5)));
    step(1'b0, 1'b1, '0);
    chk("rw_empty_drain", 64'(is_empty_o), 64'd1);

    // Read+write while full: head dropped, new flit stored
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, mk(4'(i + 1)));
    step(1'b1, 1'b1, mk(4'hE));
    chk("rw_full_full", 64'(is_full_o), 64'd1);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("rw_full_head%0d", i), 64'(data_o), (i == 7) ? 64'(mk(4'hE)) : 64'(mk(4'(i + 2))));
      step(1'b0, 1'b1, '0);
    end
    chk("rw_full_empty", 64'(is_empty_o), 64'd1);

    // Random wrap-around against queue model
    acc_wr = 0;
    for (int i = 0; i < 20; i++) begin
      if (i == 9 || i == 19) begin w = 1'b0; r = 1'b1; end
      else begin w = 1'b1; r = 1'($urandom_range(0, 1)); end
      rv = flit_t'($urandom);
      if (sb.size() > 0) chk($sformatf("rnd_head%0d", i), 64'(data_o), 64'(sb[0]));
      chk($sformatf("rnd_empty%0d", i), 64'(is_empty_o), 64'(sb.size() == 0));
      chk($sformatf("rnd_full%0d", i), 64'(is_full_o), 64'(sb.size() == 8));
      rd_ok = r && (sb.size() > 0);
      wr_ok = w && ((sb.size() < 8) || rd_ok);
      if (rd_ok) void'(sb.pop_front());
      if (wr_ok) begin sb.push_back(rv); acc_wr++; end
      step(w, r, rv);
    end
    chk("rnd_wrcount_gt16", 64'(acc_wr > 16), 64'd1);
    while (sb.size() > 0) begin
      chk("rnd_drain_head", 64'(data_o), 64'(sb.pop_front()));
      step(1'b0, 1'b1, '0);
    end
    chk("rnd_drain_empty", 64'(is_empty_o), 64'd1);

    // Reset mid-operation with 5 flits queued
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, mk(4'(i + 3)));
    chk("mid_notempty", 64'(is_empty_o), 64'd0);
    #2 rst = 1'b0;
    #1 chk("mid_rst_empty", 64'(is_empty_o), 64'd1);
    chk("mid_rst_notfull", 64'(is_full_o), 64'd0);
    @(posedge clk); #1 rst = 1'b1;
    chk("mid_hold_empty", 64'(is_empty_o), 64'd1);
    step(1'b1, 1'b0, mk(4'hD));
    chk("mid_new_head", 64'(data_o), 64'(mk(4'hD)));
    step(1'b0, 1'b1, '0);
    chk("mid_final_empty", 64'(is_empty_o), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
